spi_byte_slave: RTL and testbench

SPI_BYTE_SLAVE -- requirements
Module: spi_byte_slave

---
 rtl/spi_byte_slave_pkg.sv | 17 +
 rtl/spi_byte_slave_sync_ff.sv | 37 +++
 rtl/spi_byte_slave.sv | 171 +++++++++++++++++
 tb/tb_spi_byte_slave.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_byte_slave_pkg.sv
// rtl/spi_byte_slave_pkg.sv - shared ILA state encoding and byte-width constants
package spi_byte_slave_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;

  // Cycles spent in RELOAD after the end-of-byte pulse before sampling i_send_byte
  localparam logic [1:0] RELOAD_WAIT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_RELOAD = 2'd3
  } state_e;

endpackage

// File: rtl/spi_byte_slave_sync_ff.sv
// rtl/spi_byte_slave_sync_ff.sv - generic multi-stage synchroniser with per-bit reset level
module sync_ff #(
  parameter int              WIDTH   = 1,
  parameter int              STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  // Each stage takes the previous one; stage 0 takes the asynchronous input
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Chain resets to the idle levels of the sampled lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/spi_byte_slave.sv
// rtl/spi_byte_slave.sv - SPI mode-0 byte slave oversampled in the system clock domain
module spi_byte_slave
  import spi_byte_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk_ILA,
  input  logic              i_reset,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  input  logic [BYTE_W-1:0] i_send_byte,
  output logic              o_miso,
  output logic [BYTE_W-1:0] o_recv_byte,
  output logic              o_recv_valid,
  output logic              o_end_byte_nedge,
  output logic              o_cs_active
);

  // Synchronised lines: {sclk, cs_n, mosi}; idle levels 0, 1, 0
  logic [2:0] sync_out;
  logic       sclk_s, cs_n_s, mosi_s;

  sync_ff #(
    .WIDTH   (3),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (3'b010)
  ) u_sync (
    .clk (i_clk_ILA),
    .rst (i_reset),
    .d   ({i_sclk, i_cs_n, i_mosi}),
    .q   (sync_out)
  );

  assign sclk_s = sync_out[2];
  assign cs_n_s = sync_out[1];
  assign mosi_s = sync_out[0];

  logic                 sclk_prev_q, sclk_prev_d;
  logic                 cs_n_prev_q, cs_n_prev_d;
  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BIT_CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic [1:0]           wait_cnt_q, wait_cnt_d;
  logic [BYTE_W-1:0]    tx_q, tx_d;
  logic [BYTE_W-1:0]    rx_q, rx_d;
  logic                 miso_q, miso_d;
  logic [BYTE_W-1:0]    recv_byte_q, recv_byte_d;
  logic                 recv_valid_q, recv_valid_d;
  logic                 end_q, end_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_n_s & cs_n_prev_q;
  assign cs_rise   = cs_n_s & ~cs_n_prev_q;

  // Next-state logic: frame sequencing, shift registers and pulse generation
  always_comb begin
    sclk_prev_d  = sclk_s;
    cs_n_prev_d  = cs_n_s;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rise_cnt_d   = rise_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    miso_d       = miso_q;
    recv_byte_d  = recv_byte_q;
    recv_valid_d = 1'b0;
    end_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d     = 1'b0;
        bit_cnt_d  = '0;
        rise_cnt_d = '0;
        wait_cnt_d = '0;
        if (cs_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        tx_d    = i_send_byte;
        miso_d  = i_send_byte[BYTE_W-1];
        rx_d    = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          rx_d       = {rx_q[BYTE_W-2:0], mosi_s};
          rise_cnt_d = rise_cnt_q + 3'd1;
          if (rise_cnt_q == 3'd7) begin
            recv_byte_d  = {rx_q[BYTE_W-2:0], mosi_s};
            recv_valid_d = 1'b1;
          end
        end
        if (sclk_fall) begin
          tx_d      = {tx_q[BYTE_W-2:0], 1'b0};
          miso_d    = tx_q[BYTE_W-2];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            end_d      = 1'b1;
            wait_cnt_d = '0;
            state_d    = ST_RELOAD;
          end
        end
      end
      ST_RELOAD: begin
        // Give the upstream stage time to present the next byte after the end pulse
        if (wait_cnt_q == RELOAD_WAIT) begin
          tx_d       = i_send_byte;
          miso_d     = i_send_byte[BYTE_W-1];
          wait_cnt_d = '0;
          state_d    = ST_SHIFT;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Deselect aborts the frame; a completed 8th fall still reports its end pulse
    if (cs_rise) begin
      state_d      = ST_IDLE;
      bit_cnt_d    = '0;
      rise_cnt_d   = '0;
      wait_cnt_d   = '0;
      miso_d       = 1'b0;
      recv_byte_d  = recv_byte_q;
      recv_valid_d = 1'b0;
    end
  end

  // State and output registers with asynchronous reset to idle levels
  always_ff @(posedge i_clk_ILA or posedge i_reset) begin
    if (i_reset) begin
      sclk_prev_q  <= 1'b0;
      cs_n_prev_q  <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rise_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      miso_q       <= 1'b0;
      recv_byte_q  <= '0;
      recv_valid_q <= 1'b0;
      end_q        <= 1'b0;
    end else begin
      sclk_prev_q  <= sclk_prev_d;
      cs_n_prev_q  <= cs_n_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rise_cnt_q   <= rise_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      miso_q       <= miso_d;
      recv_byte_q  <= recv_byte_d;
      recv_valid_q <= recv_valid_d;
      end_q        <= end_d;
    end
  end

  assign o_miso           = miso_q;
  assign o_recv_byte      = recv_byte_q;
  assign o_recv_valid     = recv_valid_q;
  assign o_end_byte_nedge = end_q;
  assign o_cs_active      = ~cs_n_s;

endmodule

// File: tb/tb_spi_byte_slave.sv
// tb/tb_spi_byte_slave.sv - directed self-checking bench for spi_byte_slave
module tb_spi_byte_slave;
  import spi_byte_slave_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic [7:0] send_byte;
  logic       miso;
  logic [7:0] recv_byte;
  logic       recv_valid;
  logic       end_pulse;
  logic       cs_active;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int end_cnt   = 0;
  int valid_cnt = 0;

  logic       upd_pending = 1'b0;
  logic [7:0] next_send   = 8'h00;

  always #5 clk = ~clk;

  spi_byte_slave #(.SYNC_STAGES(2)) dut (
    .i_clk_ILA        (clk),
    .i_reset          (rst),
    .i_sclk           (sclk),
    .i_cs_n           (cs_n),
    .i_mosi           (mosi),
    .i_send_byte      (send_byte),
    .o_miso           (miso),
    .o_recv_byte      (recv_byte),
    .o_recv_valid     (recv_valid),
    .o_end_byte_nedge (end_pulse),
    .o_cs_active      (cs_active)
  );

  // Count high cycles of each pulse output
  always @(negedge clk) begin
    if (end_pulse === 1'b1) end_cnt++;
    if (recv_valid === 1'b1) valid_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle; the upstream model presents next_send one cycle after an end pulse
  task automatic step();
    @(negedge clk);
    if (upd_pending) begin
      send_byte   = next_send;
      upd_pending = 1'b0;
    end
    if (end_pulse === 1'b1) upd_pending = 1'b1;
  endtask

  // Host side of nbits SCK cycles, 4 system clocks per half period; MISO sampled late in high phase
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit cs_at_end,
                      output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      repeat (4) step();
      sclk = 1'b1;
      repeat (4) step();
      rx[i] = miso;
      sclk = 1'b0;
      if (cs_at_end && i == 0) cs_n = 1'b1;
    end
  endtask

  task automatic end_frame();
    repeat (4) step();
    cs_n = 1'b1;
    repeat (6) step();
  endtask

  logic [7:0] rxb;
  logic [7:0] send_tab [16];
  logic [7:0] host_tab [16];
  int         e0, v0;

  initial begin
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; send_byte = 8'h00;
    repeat (3) step();
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_recv_byte", {24'd0, recv_byte}, 32'h00);
    chk("rst_recv_valid", {31'd0, recv_valid}, 32'd0);
    chk("rst_end", {31'd0, end_pulse}, 32'd0);
    chk("rst_cs_active", {31'd0, cs_active}, 32'd0);
    rst = 1'b0;
    repeat (3) step();

    // Single byte: host 0xA5, slave 0x3C; cs_active latency is two cycles
    send_byte = 8'h3C; next_send = 8'h3C;
    cs_n = 1'b0;
    step();
    chk("cs_lat1", {31'd0, cs_active}, 32'd0);
    step();
    chk("cs_lat2", {31'd0, cs_active}, 32'd1);
    repeat (2) step();
    xfer(8'hA5, 8, 1'b0, rxb);
    chk("b1_miso", {24'd0, rxb}, 32'h3C);
    chk("b1_recv", {24'd0, recv_byte}, 32'hA5);
    end_frame();
    chk("b1_valid_cnt", valid_cnt, 1);
    chk("b1_end_cnt", end_cnt, 1);

    // Three-byte frame with upstream reload
    send_byte = 8'h11; next_send = 8'h11;
    cs_n = 1'b0;
    repeat (4) step();
    xfer(8'hC3, 8, 1'b0, rxb);
    chk("f3_miso0", {24'd0, rxb}, 32'h11);
    chk("f3_recv0", {24'd0, recv_byte}, 32'hC3);
    next_send = 8'h22;
    xfer(8'h5A, 8, 1'b0, rxb);
    chk("f3_miso1", {24'd0, rxb}, 32'h22);
    chk("f3_recv1", {24'd0, recv_byte}, 32'h5A);
    next_send = 8'h33;
    xfer(8'h96, 8, 1'b0, rxb);
    chk("f3_miso2", {24'd0, rxb}, 32'h33);
    chk("f3_recv2", {24'd0, recv_byte}, 32'h96);
    end_frame();
    chk("f3_end_cnt", end_cnt, 4);
    chk("f3_valid_cnt", valid_cnt, 4);

    // Aborted frame after 5 SCK cycles, then a clean 0xFF frame
    send_byte = 8'h81; next_send = 8'h81;
    cs_n = 1'b0;
    repeat (4) step();
    xfer(8'h0F, 5, 1'b0, rxb);
    end_frame();
    chk("ab_end_cnt", end_cnt, 4);
    chk("ab_valid_cnt", valid_cnt, 4);
    chk("ab_recv_kept", {24'd0, recv_byte}, 32'h96);
    chk("ab_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    chk("ab_miso", {31'd0, miso}, 32'd0);
    cs_n = 1'b0;
    repeat (4) step();
    xfer(8'hFF, 8, 1'b0, rxb);
    chk("ff_miso", {24'd0, rxb}, 32'h81);
    chk("ff_recv", {24'd0, recv_byte}, 32'hFF);
    end_frame();
    chk("ff_end_cnt", end_cnt, 5);

    // Reset during the 4th SCK high phase
    send_byte = 8'h24; next_send = 8'h24;
    cs_n = 1'b0;
    repeat (4) step();
    xfer(8'hC3, 3, 1'b0, rxb);
    mosi = 1'b0;
    repeat (4) step();
    sclk = 1'b1;
    repeat (2) step();
    e0 = end_cnt; v0 = valid_cnt;
    rst = 1'b1;
    #1;
    chk("mr_miso", {31'd0, miso}, 32'd0);
    chk("mr_recv_byte", {24'd0, recv_byte}, 32'h00);
    chk("mr_valid", {31'd0, recv_valid}, 32'd0);
    chk("mr_end", {31'd0, end_pulse}, 32'd0);
    chk("mr_cs_active", {31'd0, cs_active}, 32'd0);
    sclk = 1'b0; cs_n = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();
    chk("mr_no_end", end_cnt - e0, 0);
    chk("mr_no_valid", valid_cnt - v0, 0);
    send_byte = 8'hE7; next_send = 8'hE7;
    cs_n = 1'b0;
    repeat (4) step();
    xfer(8'h5A, 8, 1'b0, rxb);
    chk("pr_miso", {24'd0, rxb}, 32'hE7);
    chk("pr_recv", {24'd0, recv_byte}, 32'h5A);
    end_frame();

    // 16-byte random loopback at the minimum clock ratio
    for (int k = 0; k < 16; k++) begin
      send_tab[k] = 8'($urandom_range(0, 255));
      host_tab[k] = 8'($urandom_range(0, 255));
    end
    e0 = end_cnt;
    send_byte = send_tab[0]; next_send = send_tab[0];
    cs_n = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 16; k++) begin
      next_send = send_tab[k];
      xfer(host_tab[k], 8, 1'b0, rxb);
      chk($sformatf("lb_miso%0d", k), {24'd0, rxb}, {24'd0, send_tab[k]});
      chk($sformatf("lb_recv%0d", k), {24'd0, recv_byte}, {24'd0, host_tab[k]});
    end
    end_frame();
    chk("lb_end_cnt", end_cnt - e0, 16);

    // CS rise coincident with the 8th SCK fall
    e0 = end_cnt; v0 = valid_cnt;
    send_byte = 8'h6B; next_send = 8'h6B;
    cs_n = 1'b0;
    repeat (4) step();
    xfer(8'h3D, 8, 1'b1, rxb);
    repeat (8) step();
    chk("cc_miso", {24'd0, rxb}, 32'h6B);
    chk("cc_recv", {24'd0, recv_byte}, 32'h3D);
    chk("cc_end_cnt", end_cnt - e0, 1);
    chk("cc_valid_cnt", valid_cnt - v0, 1);
    chk("cc_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    chk("cc_cs_active", {31'd0, cs_active}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
